instr_issuer: RTL and testbench
===============================

# instr_issuer

Host-side instruction issuer that drives the `cpu` block's `in`/`load`/`s`/`w` handshake. The host pushes 16-bit instruction words into a small FIFO and pulses `start`. The issuer then presents each word on `cpu_in`, loads it, starts the CPU, and waits for the CPU to return to its wait state. After each instruction it captures `out` and the N/V/Z flags as one result. It sits between a test/host controller and the CPU, as the initiator end of the CPU's command interface.

## Interface
- `DEPTH`, default 8: FIFO entries; a power of two, minimum 2.
- `TIMEOUT`, default 255: maximum cycles allowed in LEAVE+WAIT per instruction.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `wr_valid`  in  1  host presents an instruction word.
- `wr_data`  in  16  instruction word.
- `wr_ready`  out  1  FIFO not full.
- `start`  in  1  one-cycle pulse that begins a run.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `cpu_in`  out  16  instruction to the CPU.
- `cpu_load`  out  1  instruction-register load strobe.
- `cpu_s`  out  1  CPU start strobe.
- `cpu_w`  in  1  CPU is in its wait state.
- `cpu_out`  in  16  CPU datapath output.
- `cpu_N`, `cpu_V`, `cpu_Z`  in  1 each  CPU status flags.
- `res_data`  out  16  captured `cpu_out`.
- `res_flags`  out  3  captured {N,V,Z}.
- `res_valid`  out  1  one-cycle pulse when a result is captured.
- `timeout`  out  1  sticky error flag.

## Operation
- FIFO push occurs on `wr_valid && wr_ready`. `wr_ready = (count < DEPTH)`. Pushes are legal at any time, including while busy.
- The FSM has states IDLE, LOAD, START, LEAVE, WAIT, CAPTURE, ERR.
- IDLE: on `start`:
  - FIFO empty: pulse `done` next cycle; no CPU activity.
  - otherwise: wait until `cpu_w=1`, then go to LOAD.
- LOAD: `cpu_in` = FIFO head; `cpu_load=1` for exactly one cycle; go to START.
- START: `cpu_s=1` for exactly one cycle; clear the timeout counter; go to LEAVE.
- LEAVE: wait for `cpu_w=0`, then go to WAIT.
- WAIT: wait for `cpu_w=1`, then go to CAPTURE.
- CAPTURE: register `cpu_out` into `res_data` and {N,V,Z} into `res_flags`; pulse `res_valid`; pop the FIFO.
  - FIFO non-empty after the pop: go to LOAD.
  - otherwise: pulse `done` and go to IDLE.
- Timeout: the counter increments each cycle in LEAVE/WAIT. When it reaches `TIMEOUT`, go to ERR and set `timeout`.
- ERR: `busy` stays 1 and no CPU strobes are driven. A `start` pulse flushes the FIFO, clears `timeout`, and returns to IDLE.
- `start` is ignored while busy outside ERR.
- Push and pop in the same cycle (CAPTURE) both take effect; `count` is unchanged. Pushes are refused when full even if a pop occurs that cycle.
- `busy` = 1 in every state except IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `wr_ready=1`
  - `busy`, `done`, `cpu_load`, `cpu_s`, `res_valid`, `timeout` = 0
  - `count`, `cpu_in`, `res_data`, `res_flags` = 0
- Per-instruction overhead is 3 cycles (LOAD, START, CAPTURE) plus the CPU execution time seen in LEAVE/WAIT, minimum 2. Back-to-back instructions therefore issue at most every 5 cycles.
- `cpu_in` holds its value from LOAD until the next LOAD.
- `res_valid` and `done` coincide on the last instruction's capture cycle.
- Reset mid-run:
  - FIFO flushed, FSM to IDLE.
  - `cpu_load`/`cpu_s` drop asynchronously.
  - No `done` or `res_valid` is emitted.

## Configuration
- `INSTR_ISSUER_HALT_EN` defined: a head word with `[15:13]==3'b111` reached in CAPTURE→LOAD or IDLE→LOAD is treated as a halt.
  - It is popped without being issued: no `cpu_load`/`cpu_s`, no `res_valid`.
  - The run ends with a `done` pulse; remaining FIFO entries are kept for the next `start`.
- Not defined: every word is issued verbatim, including opcode 111.

## Test plan
- Push 0xD105, 0xD203, 0xA0A1; pulse `start`. A CPU model drops `w` 1 cycle after `s` and raises it 3 cycles later, `cpu_out`=0x0008. Expected:
  - three `cpu_load`/`cpu_s` pairs, in push order;
  - three `res_valid` pulses with `res_data`=0x0008;
  - `done` on the third pulse.
- Push 8 words: `wr_ready` falls after the 8th and `count`=8. A 9th push is refused. During the run, a push in a CAPTURE cycle that follows another CAPTURE keeps `count` constant.
- CPU model never drops `w` after `s`, `TIMEOUT`=255: ERR reached 255 cycles after START with `timeout`=1 and no `res_valid`. A `start` pulse then clears `timeout`, sets `count`=0, and returns `busy`=0.
- Assert `reset`=0 while in WAIT with 2 words queued: `busy`, `cpu_s`, `cpu_load` drop immediately and `count`=0. No `done` occurs after release.
- `start` with the FIFO empty: a single `done` pulse one cycle later, with `busy` staying 0.
- With `INSTR_ISSUER_HALT_EN`, push 0xD105, 0xE000, 0xD203; `start`: one instruction issued, `done`, `count`=1. A second `start` issues 0xD203.

Source files
------------

// File: rtl/instr_issuer.sv
// instr_issuer: FIFO-fed issuer driving the cpu in/load/s/w handshake.
// Define INSTR_ISSUER_HALT_EN to treat opcode 3'b111 head words as a halt.
module instr_issuer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [15:0]              wr_data,
  output logic                     wr_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              cpu_in,
  output logic                     cpu_load,
  output logic                     cpu_s,
  input  logic                     cpu_w,
  input  logic [15:0]              cpu_out,
  input  logic                     cpu_N,
  input  logic                     cpu_V,
  input  logic                     cpu_Z,
  output logic [15:0]              res_data,
  output logic [2:0]               res_flags,
  output logic                     res_valid,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
`ifdef INSTR_ISSUER_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_LEAVE,
    S_WAIT, S_CAPTURE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           pend_q, pend_d;
  logic           wr_ready_q, wr_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [15:0]    cpu_in_q, cpu_in_d;
  logic           cpu_load_q, cpu_load_d;
  logic           cpu_s_q, cpu_s_d;
  logic [15:0]    res_data_q, res_data_d;
  logic [2:0]     res_flags_q, res_flags_d;
  logic           res_valid_q, res_valid_d;
  logic           timeout_q, timeout_d;

  logic           push;
  logic           flush;
  logic [1:0]     pops;
  logic [15:0]    head;
  logic [15:0]    nxt_head;
  logic [CW-1:0]  left;
  logic [TW-1:0]  tinc;

  assign push     = wr_valid && wr_ready_q;
  assign head     = mem_q[rd_ptr_q];
  // Head after this cycle's pop; may be the word being pushed right now.
  assign nxt_head = (count_q > CW'(1)) ? mem_q[rd_ptr_q + AW'(1)]
                                       : wr_data;
  assign left     = count_q - CW'(1) + CW'(push);
  assign tinc     = tcnt_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    pend_d      = pend_q;
    pops        = 2'd0;
    flush       = 1'b0;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    cpu_in_d    = cpu_in_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start || pend_q) begin
          if (count_q == '0) begin
            pend_d = 1'b0;
            done_d = 1'b1;
          end else if (cpu_w) begin
            pend_d = 1'b0;
            if (HALT_EN && head[15:13] == 3'b111) begin
              pops   = 2'd1;
              done_d = 1'b1;
            end else begin
              state_d  = S_LOAD;
              cpu_in_d = head;
            end
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        tcnt_d  = '0;
        state_d = S_LEAVE;
      end
      S_LEAVE, S_WAIT: begin
        tcnt_d = tinc;
        if (state_q == S_LEAVE && !cpu_w) begin
          state_d = S_WAIT;
        end else if (state_q == S_WAIT && cpu_w) begin
          state_d = S_CAPTURE;
        end else if (tinc == TMAX) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        res_data_d  = cpu_out;
        res_flags_d = {cpu_N, cpu_V, cpu_Z};
        res_valid_d = 1'b1;
        pops        = 2'd1;
        if (left == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (HALT_EN && nxt_head[15:13] == 3'b111) begin
          pops    = 2'd2;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d  = S_LOAD;
          cpu_in_d = nxt_head;
        end
      end
      S_ERR: begin
        if (start) begin
          flush     = 1'b1;
          timeout_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CW'(push);
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pops);
      count_d  = count_q + CW'(push) - CW'(pops);
    end

    wr_ready_d = (count_d != CW'(DEPTH));
    busy_d     = (state_d != S_IDLE);
    cpu_load_d = (state_d == S_LOAD);
    cpu_s_d    = (state_d == S_START);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      tcnt_q      <= '0;
      pend_q      <= 1'b0;
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_in_q    <= '0;
      cpu_load_q  <= 1'b0;
      cpu_s_q     <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      tcnt_q      <= tcnt_d;
      pend_q      <= pend_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cpu_in_q    <= cpu_in_d;
      cpu_load_q  <= cpu_load_d;
      cpu_s_q     <= cpu_s_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign cpu_in    = cpu_in_q;
  assign cpu_load  = cpu_load_q;
  assign cpu_s     = cpu_s_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: directed vectors and cycle traces for instr_issuer.
// A small CPU model answers cpu_s by dropping w for three cycles.
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        start = 1'b0;
  logic        busy, done;
  logic [3:0]  count;
  logic [15:0] cpu_in;
  logic        cpu_load, cpu_s;
  logic        cpu_w = 1'b1;
  logic [15:0] cpu_out = 16'h0008;
  logic        cpu_N = 1'b1;
  logic        cpu_V = 1'b0;
  logic        cpu_Z = 1'b0;
  logic [15:0] res_data;
  logic [2:0]  res_flags;
  logic        res_valid, timeout;

  always #5 clk = ~clk;

  instr_issuer #(.DEPTH(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .busy(busy), .done(done), .count(count),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s),
    .cpu_w(cpu_w), .cpu_out(cpu_out),
    .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .res_data(res_data), .res_flags(res_flags),
    .res_valid(res_valid), .timeout(timeout)
  );

  int checks = 0;
  int passed = 0;
  int hang = 0;
  int wcnt = 0;

  always @(negedge clk) begin
    if (cpu_s && hang == 0) begin
      cpu_w = 1'b0;
      wcnt  = 3;
    end else if (wcnt > 0) begin
      wcnt = wcnt - 1;
      if (wcnt == 0) cpu_w = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int max, output bit seen,
                     output int rvs, output int loads);
    seen  = 1'b0;
    rvs   = 0;
    loads = 0;
    start = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      start = 1'b0;
      if (res_valid) rvs++;
      if (cpu_load) loads++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic busy, load, s, rv, done;
    logic [15:0] in;
  } trace_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [3:0]  cnt;
    logic        rdy;
  } fill_t;

  trace_t tr[20];
  fill_t  fv[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int rvs, loads, rv;

    for (int k = 0; k < 20; k++) begin
      tr[k].busy = (k < 18);
      tr[k].load = (k < 18) && (k % 6 == 0);
      tr[k].s    = (k < 18) && (k % 6 == 1);
      tr[k].rv   = (k > 0) && (k < 20) && (k % 6 == 0);
      tr[k].done = (k == 18);
      tr[k].in   = (k < 6) ? 16'hD105 :
                   (k < 12) ? 16'hD203 : 16'hA0A1;
    end
    for (int i = 0; i < 9; i++) begin
      fv[i].v   = 1'b1;
      fv[i].d   = 16'h1000 + 16'(i);
      fv[i].cnt = (i < 8) ? 4'(i + 1) : 4'd8;
      fv[i].rdy = (i < 7);
    end

    // reset values
    #12;
    chk("rst wr_ready", wr_ready, 1);
    chk("rst outs", {busy, done, cpu_load, cpu_s, res_valid, timeout}, 0);
    chk("rst count", count, 0);
    chk("rst data", {cpu_in, res_data, res_flags}, 0);
    tick();
    reset = 1'b1;
    tick();

    // three-instruction run, cycle trace
    push(16'hD105);
    push(16'hD203);
    push(16'hA0A1);
    chk("count3", count, 3);
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("trace[%0d]", k),
          {busy, cpu_load, cpu_s, res_valid, done, cpu_in},
          {tr[k].busy, tr[k].load, tr[k].s, tr[k].rv, tr[k].done,
           tr[k].in});
      if (tr[k].rv) chk($sformatf("res[%0d]", k),
                        {res_flags, res_data}, {3'b100, 16'h0008});
      tick();
    end
    chk("count after run", count, 0);

    // fill to full, ninth push refused
    for (int i = 0; i < 9; i++) begin
      wr_valid = fv[i].v;
      wr_data  = fv[i].d;
      tick();
      wr_valid = 1'b0;
      chk($sformatf("fill[%0d]", i), {wr_ready, count},
          {fv[i].rdy, fv[i].cnt});
    end

    // pops during capture while pushing
    pulse_start();
    repeat (5) tick();
    chk("full at cap1", {wr_ready, count}, {1'b0, 4'd8});
    wr_valid = 1'b1;
    wr_data  = 16'h2000;
    tick();
    wr_valid = 1'b0;
    chk("cap1 refused", count, 7);
    repeat (5) tick();
    chk("cap2 before", {wr_ready, count}, {1'b1, 4'd7});
    wr_valid = 1'b1;
    wr_data  = 16'h2001;
    tick();
    wr_valid = 1'b0;
    chk("cap2 push+pop", count, 7);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("full run done", seen, 1);
    chk("full run last", {count, cpu_in}, {4'd0, 16'h2001});
    tick();

    // timeout
    hang = 1;
    push(16'hD105);
    pulse_start();
    tick();
    chk("to cpu_s", cpu_s, 1);
    rv = 0;
    repeat (255) begin
      tick();
      if (res_valid) rv++;
    end
    chk("to before", timeout, 0);
    tick();
    chk("to after", {timeout, busy, cpu_s, cpu_load}, 4'b1100);
    chk("to no rv", rv, 0);
    repeat (3) tick();
    chk("err held", {timeout, busy, count}, {2'b11, 4'd1});
    hang = 0;
    pulse_start();
    chk("err clear", {timeout, busy, count}, {2'b00, 4'd0});
    tick();

    // reset in WAIT with two words queued
    push(16'hD105);
    push(16'hD203);
    pulse_start();
    repeat (3) tick();
    chk("pre rst", {busy, count}, {1'b1, 4'd2});
    reset = 1'b0;
    #1;
    chk("async rst", {busy, cpu_s, cpu_load, count}, 7'b0);
    tick();
    reset = 1'b1;
    rv = 0;
    repeat (10) begin
      tick();
      if (done || res_valid || busy) rv++;
    end
    chk("quiet after rst", rv, 0);

    // reset while cpu_s is high
    push(16'hD105);
    pulse_start();
    tick();
    chk("s high", cpu_s, 1);
    reset = 1'b0;
    #1;
    chk("s async drop", {cpu_s, busy, count}, 6'b0);
    tick();
    reset = 1'b1;
    repeat (6) tick();

    // start with empty FIFO
    pulse_start();
    chk("empty done", {done, busy, cpu_load}, 3'b100);
    tick();
    chk("empty after", {done, busy}, 2'b00);

`ifdef INSTR_ISSUER_HALT_EN
    push(16'hD105);
    push(16'hE000);
    push(16'hD203);
    run(50, seen, rvs, loads);
    chk("halt1 done", seen, 1);
    chk("halt1 issued", {8'(rvs), 8'(loads), 4'(count)},
        {8'd1, 8'd1, 4'd1});
    chk("halt1 in", cpu_in, 16'hD105);
    tick();
    run(50, seen, rvs, loads);
    chk("halt2 done", seen, 1);
    chk("halt2 issued", {8'(rvs), 8'(loads), 4'(count)},
        {8'd1, 8'd1, 4'd0});
    chk("halt2 in", cpu_in, 16'hD203);
`else
    push(16'hE000);
    run(50, seen, rvs, loads);
    chk("op111 done", seen, 1);
    chk("op111 issued", {8'(rvs), 8'(loads), 4'(count)},
        {8'd1, 8'd1, 4'd0});
    chk("op111 in", cpu_in, 16'hE000);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
